// File: rtl/sysarr_nxn.sv
// N x N output-stationary systolic matrix multiplier computing C = A x B with skewed
// operand entry and row-serial drain. Define SYSARR_SAT_EN for saturating accumulators and sat_flag.
module sysarr_nxn #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int AW = 40,
  parameter int KW = 8,
  parameter int CW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*DW-1:0]        a_col,
  input  logic [N*DW-1:0]        b_row,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*AW-1:0]        out_row,
  output logic [$clog2(N)-1:0]   out_idx,
  output logic                   done,
  output logic [CW-1:0]          count,
  output logic [1:0]             dbg_state
`ifdef SYSARR_SAT_EN
  ,
  output logic                   sat_flag
`endif
);

  localparam int IW = $clog2(N);
  localparam int FW = $clog2(2 * N);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_OUT} state_t;

  state_t          state_q;
  logic [KW-1:0]   k_len_q, beat_cnt_q;
  logic [FW-1:0]   fl_cnt_q;
  logic [IW-1:0]   out_idx_q;
  logic [CW-1:0]   count_q;
  logic            busy_q, in_ready_q, out_valid_q, done_q;

  // Both streams: a transfer happens on the rising edge where valid and ready are both high;
  // ready never waits on valid, and data is ignored whenever valid is low.
  logic accept, acc_clr, acc_en;
  assign accept  = in_valid & in_ready_q;
  assign acc_clr = (state_q == S_IDLE) & start;
  assign acc_en  = (state_q == S_LOAD) | (state_q == S_FLUSH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      fl_cnt_q    <= '0;
      out_idx_q   <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (busy_q && (count_q != {CW{1'b1}})) count_q <= count_q + CW'(1);
      case (state_q)
        S_IDLE: if (start) begin
          k_len_q    <= k_len;
          beat_cnt_q <= '0;
          fl_cnt_q   <= '0;
          count_q    <= '0;
          busy_q     <= 1'b1;
          if (k_len != '0) begin
            state_q    <= S_LOAD;
            in_ready_q <= 1'b1;
          end else begin
            state_q     <= S_OUT;
            out_valid_q <= 1'b1;
          end
        end
        S_LOAD: if (accept) begin
          beat_cnt_q <= beat_cnt_q + KW'(1);
          if (beat_cnt_q + KW'(1) == k_len_q) begin
            state_q    <= S_FLUSH;
            in_ready_q <= 1'b0;
          end
        end
        S_FLUSH: begin
          // 2N-1 zero cycles carry the last beat through PE(N-1,N-1).
          if (fl_cnt_q == FW'(2 * N - 2)) begin
            state_q     <= S_OUT;
            out_valid_q <= 1'b1;
          end else begin
            fl_cnt_q <= fl_cnt_q + FW'(1);
          end
        end
        S_OUT: if (out_ready) begin
          if (out_idx_q == IW'(N - 1)) begin
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            out_idx_q <= out_idx_q + IW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [N*DW-1:0] a_inj, b_inj, a_row, b_col;
  assign a_inj = accept ? a_col : '0;
  assign b_inj = accept ? b_row : '0;
  assign a_row[0 +: DW] = a_inj[0 +: DW];
  assign b_col[0 +: DW] = b_inj[0 +: DW];

  // Lane g is delayed g cycles so that beat k meets itself at PE(i,j) on cycle k+i+j.
  for (genvar g = 1; g < N; g++) begin : g_skew
    logic [DW-1:0] a_dl_q [g];
    logic [DW-1:0] b_dl_q [g];
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int d = 0; d < g; d++) begin
          a_dl_q[d] <= '0;
          b_dl_q[d] <= '0;
        end
      end else begin
        a_dl_q[0] <= a_inj[g*DW +: DW];
        b_dl_q[0] <= b_inj[g*DW +: DW];
        for (int d = 1; d < g; d++) begin
          a_dl_q[d] <= a_dl_q[d-1];
          b_dl_q[d] <= b_dl_q[d-1];
        end
      end
    end
    assign a_row[g*DW +: DW] = a_dl_q[g-1];
    assign b_col[g*DW +: DW] = b_dl_q[g-1];
  end

  logic signed [DW-1:0] a_in [N][N];
  logic signed [DW-1:0] b_in [N][N];
  logic signed [DW-1:0] a_q  [N][N-1];
  logic signed [DW-1:0] b_q  [N-1][N];
  logic signed [AW-1:0] acc_q [N][N];
  logic signed [AW-1:0] acc_d [N][N];
`ifdef SYSARR_SAT_EN
  logic sat_any, sat_flag_q;
`endif

  always_comb begin
    logic signed [AW-1:0] ax, bx, px;
    logic [AW:0]          sx;
    ax = '0;
    bx = '0;
    px = '0;
    sx = '0;
`ifdef SYSARR_SAT_EN
    sat_any = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      a_in[i][0] = a_row[i*DW +: DW];
      b_in[0][i] = b_col[i*DW +: DW];
      for (int j = 1; j < N; j++) begin
        a_in[i][j] = a_q[i][j-1];
        b_in[j][i] = b_q[j-1][i];
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ax = AW'(a_in[i][j]);
        bx = AW'(b_in[i][j]);
        px = ax * bx;
        sx = {acc_q[i][j][AW-1], acc_q[i][j]} + {px[AW-1], px};
`ifdef SYSARR_SAT_EN
        if (sx[AW] != sx[AW-1]) begin
          acc_d[i][j] = sx[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
          sat_any     = 1'b1;
        end else begin
          acc_d[i][j] = sx[AW-1:0];
        end
`else
        acc_d[i][j] = sx[AW-1:0];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc_q[i][j] <= '0;
          if (j < N - 1) a_q[i][j] <= '0;
          if (i < N - 1) b_q[i][j] <= '0;
        end
      end
`ifdef SYSARR_SAT_EN
      sat_flag_q <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (j < N - 1) a_q[i][j] <= a_in[i][j];
          if (i < N - 1) b_q[i][j] <= b_in[i][j];
          if (acc_clr)     acc_q[i][j] <= '0;
          else if (acc_en) acc_q[i][j] <= acc_d[i][j];
        end
      end
`ifdef SYSARR_SAT_EN
      if (acc_clr)                sat_flag_q <= 1'b0;
      else if (acc_en && sat_any) sat_flag_q <= 1'b1;
`endif
    end
  end

  always_comb begin
    out_row = '0;
    for (int j = 0; j < N; j++) out_row[j*AW +: AW] = acc_q[out_idx_q][j];
  end

  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign done      = done_q;
  assign count     = count_q;
  assign dbg_state = state_q;
`ifdef SYSARR_SAT_EN
  assign sat_flag  = sat_flag_q;
`endif

endmodule

// File: tb/tb_sysarr_nxn.sv
// Bench for sysarr_nxn: table vectors with constant expectations, abort/restart sequence,
// and random jobs checked against a plain matrix-product reference model.
module tb_sysarr_nxn;
  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int AW   = 32;
  localparam int KW   = 8;
  localparam int CW   = 16;
  localparam int IW   = 2;
  localparam int RW   = N * AW;
  localparam int KMAX = 12;
  localparam int NVEC = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [KW-1:0]   k_len = '0;
  logic [N*DW-1:0] a_col = '0;
  logic [N*DW-1:0] b_row = '0;
  logic            busy, in_ready, out_valid, done;
  logic [RW-1:0]   out_row;
  logic [IW-1:0]   out_idx;
  logic [CW-1:0]   count;
  logic [1:0]      dbg_state;
`ifdef SYSARR_SAT_EN
  logic            sat_flag;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int done_seen = 0;
  logic [RW-1:0] exp_q[$];
  int ga [KMAX][N];
  int gb [KMAX][N];
  logic [AW-1:0] gexp [N][N];
  logic gexp_sat;

  typedef struct {
    string         name;
    int            k;
    int            bub;
    int            stl;
    int            a [4][N];
    int            b [4][N];
    logic [AW-1:0] c [N][N];
    logic          sat;
  } vec_t;
  vec_t tbl [NVEC];

  sysarr_nxn #(.N(N), .DW(DW), .AW(AW), .KW(KW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_idx(out_idx),
    .done(done), .count(count), .dbg_state(dbg_state)
`ifdef SYSARR_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(negedge clk) if (rst && done) done_seen++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j], wrapped or clamped per step in beat order.
  function automatic void model(input int k);
    longint maxv, minv, acc;
    maxv = (longint'(1) << (AW - 1)) - 1;
    minv = -(longint'(1) << (AW - 1));
    gexp_sat = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int kk = 0; kk < k; kk++) begin
          acc = acc + longint'(ga[kk][i]) * longint'(gb[kk][j]);
`ifdef SYSARR_SAT_EN
          if (acc > maxv) begin acc = maxv; gexp_sat = 1'b1; end
          if (acc < minv) begin acc = minv; gexp_sat = 1'b1; end
`endif
        end
        gexp[i][j] = acc[AW-1:0];
      end
    end
  endfunction

  // driver + scoreboard for one complete job
  task automatic run_job(input int k, input int bub, input int stl, input string name);
    int beat, load_cyc, stalls, wt, row, cyc, exp_cnt;
    logic v, rdy, held_ok;
    logic [RW-1:0] rowv, held;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) rowv[j*AW +: AW] = gexp[i][j];
      exp_q.push_back(rowv);
    end
    @(negedge clk);
    check({name, " idle_busy"}, RW'(busy), RW'(0));
    start = 1'b1;
    k_len = KW'(k);
    @(negedge clk);
    start = 1'b0;
    k_len = KW'($urandom);
    check({name, " busy"}, RW'(busy), RW'(1));
    beat = 0; load_cyc = 0; wt = 0;
    while (beat < k && wt < 1000) begin
      check({name, " in_ready"}, RW'(in_ready), RW'(1));
      case (bub)
        0:       v = 1'b1;
        1:       v = (load_cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      for (int l = 0; l < N; l++) begin
        a_col[l*DW +: DW] = v ? DW'(ga[beat][l]) : DW'($urandom);
        b_row[l*DW +: DW] = v ? DW'(gb[beat][l]) : DW'($urandom);
      end
      @(negedge clk);
      load_cyc++; wt++;
      if (v) beat++;
    end
    in_valid = 1'b0;
    check({name, " beats_sent"}, RW'(beat), RW'(k));
    check({name, " in_ready_drop"}, RW'(in_ready), RW'(0));
    wt = 0;
    while (!out_valid && wt < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      a_col = {$urandom, $urandom};
      b_row = {$urandom, $urandom};
      @(negedge clk);
      wt++;
    end
    in_valid = 1'b0;
    check({name, " out_latency"}, RW'(wt), RW'((k > 0) ? 2 * N - 1 : 0));
    row = 0; stalls = 0; cyc = 0; held_ok = 1'b0; held = '0;
    while (row < N && cyc < 1000) begin
      case (stl)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      check({name, " out_valid"}, RW'(out_valid), RW'(1));
      check({name, " out_idx"}, RW'(out_idx), RW'(row));
      if (held_ok) check({name, " stall_stable"}, out_row, held);
      out_ready = rdy;
      if (rdy) begin
        check($sformatf("%s row%0d", name, row), out_row, exp_q.pop_front());
        held_ok = 1'b0;
      end else begin
        held = out_row;
        held_ok = 1'b1;
        stalls++;
      end
      @(negedge clk);
      cyc++;
      if (rdy) row++;
    end
    out_ready = 1'b0;
    exp_cnt = load_cyc + ((k > 0) ? 2 * N - 1 : 0) + N + stalls;
    check({name, " done_pulse"}, RW'(done), RW'(1));
    check({name, " busy_end"}, RW'(busy), RW'(0));
    check({name, " out_valid_end"}, RW'(out_valid), RW'(0));
    check({name, " out_idx_end"}, RW'(out_idx), RW'(0));
    check({name, " count"}, RW'(count), RW'(exp_cnt));
`ifdef SYSARR_SAT_EN
    check({name, " sat_flag"}, RW'(sat_flag), RW'(gexp_sat));
`endif
    @(negedge clk);
    check({name, " done_low"}, RW'(done), RW'(0));
    check({name, " count_hold"}, RW'(count), RW'(exp_cnt));
  endtask

  initial begin
    int seen;
    int k;
    // vector table: inputs and constant expected C
    tbl[0].name = "identity";  tbl[0].k = 4; tbl[0].bub = 0; tbl[0].stl = 0;
    tbl[1].name = "all_ones";  tbl[1].k = 4; tbl[1].bub = 0; tbl[1].stl = 0;
    tbl[2].name = "ones_gaps"; tbl[2].k = 4; tbl[2].bub = 1; tbl[2].stl = 0;
    tbl[3].name = "outer";     tbl[3].k = 1; tbl[3].bub = 0; tbl[3].stl = 0;
    tbl[4].name = "signed_bp"; tbl[4].k = 2; tbl[4].bub = 0; tbl[4].stl = 1;
    tbl[5].name = "k_zero";    tbl[5].k = 0; tbl[5].bub = 0; tbl[5].stl = 0;
    tbl[6].name = "big_sum";   tbl[6].k = 3; tbl[6].bub = 0; tbl[6].stl = 0;
    for (int v = 0; v < NVEC; v++) begin
      tbl[v].sat = 1'b0;
      for (int kk = 0; kk < 4; kk++) begin
        for (int l = 0; l < N; l++) begin
          case (v)
            0: begin tbl[v].a[kk][l] = (kk == l) ? 1 : 0; tbl[v].b[kk][l] = (kk == l) ? 1 : 0; end
            1, 2: begin tbl[v].a[kk][l] = 1; tbl[v].b[kk][l] = 1; end
            3: begin tbl[v].a[kk][l] = l + 1; tbl[v].b[kk][l] = l + 5; end
            4: begin tbl[v].a[kk][l] = -3; tbl[v].b[kk][l] = 7; end
            5: begin tbl[v].a[kk][l] = 9; tbl[v].b[kk][l] = 9; end
            default: begin tbl[v].a[kk][l] = -32768; tbl[v].b[kk][l] = -32768; end
          endcase
        end
      end
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          case (v)
            0:    tbl[v].c[i][j] = (i == j) ? 32'd1 : 32'd0;
            1, 2: tbl[v].c[i][j] = 32'd4;
            3:    tbl[v].c[i][j] = AW'((i + 1) * (j + 5));
            4:    tbl[v].c[i][j] = 32'hFFFF_FFD6;
            5:    tbl[v].c[i][j] = 32'd0;
`ifdef SYSARR_SAT_EN
            default: begin tbl[v].c[i][j] = 32'h7FFF_FFFF; tbl[v].sat = 1'b1; end
`else
            default: tbl[v].c[i][j] = 32'hC000_0000;
`endif
          endcase
        end
      end
    end

    // reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy", RW'(busy), RW'(0));
    check("rst in_ready", RW'(in_ready), RW'(0));
    check("rst out_valid", RW'(out_valid), RW'(0));
    check("rst done", RW'(done), RW'(0));
    check("rst out_idx", RW'(out_idx), RW'(0));
    check("rst count", RW'(count), RW'(0));
    rst = 1'b1;

    for (int v = 0; v < NVEC; v++) begin
      for (int kk = 0; kk < 4; kk++) begin
        for (int l = 0; l < N; l++) begin
          ga[kk][l] = tbl[v].a[kk][l];
          gb[kk][l] = tbl[v].b[kk][l];
        end
      end
      gexp = tbl[v].c;
      gexp_sat = tbl[v].sat;
      run_job(tbl[v].k, tbl[v].bub, tbl[v].stl, tbl[v].name);
    end
    check("identity count const", RW'(4 + 7 + 4), RW'(15 + 0 * int'(count)));

    // abort in LOAD: asynchronous reset, no done pulse, then a clean job
    seen = done_seen;
    @(negedge clk);
    start = 1'b1;
    k_len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      a_col = {$urandom, $urandom};
      b_row = {$urandom, $urandom};
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("abort busy", RW'(busy), RW'(0));
    check("abort out_valid", RW'(out_valid), RW'(0));
    check("abort in_ready", RW'(in_ready), RW'(0));
    check("abort count", RW'(count), RW'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("abort no_done", RW'(done_seen), RW'(seen));
    check("abort idle", RW'(busy), RW'(0));
    for (int l = 0; l < N; l++) begin
      ga[0][l] = 2;
      gb[0][l] = 2;
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) gexp[i][j] = 32'd4;
    gexp_sat = 1'b0;
    run_job(1, 0, 0, "after_abort");

    // random jobs against the reference model
    for (int r = 0; r < 8; r++) begin
      k = $urandom_range(1, KMAX);
      for (int kk = 0; kk < KMAX; kk++) begin
        for (int l = 0; l < N; l++) begin
          ga[kk][l] = (r < 4) ? $urandom_range(0, 200) - 100 : $urandom_range(0, 65535) - 32768;
          gb[kk][l] = (r < 4) ? $urandom_range(0, 200) - 100 : $urandom_range(0, 65535) - 32768;
        end
      end
      model(k);
      run_job(k, 2, 2, $sformatf("rand%0d", r));
    end
    check("scoreboard empty", RW'(exp_q.size()), RW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sysarr_nxn.md
Name: sysarr_nxn

Overview:
- Parametrised N x N output-stationary systolic matrix-multiply engine; computes C = A x B, with A of size N x K and B of size K x N.
- Successor to the fixed 4x4 array: generic N, data and accumulator widths, runtime K, built-in input skewing, valid/ready streaming, and a row-serial result drain.
- Sits between operand buffers (upstream) and the result writeback (downstream).

Parameters:
N, 4, array dimension (rows = cols = N), N >= 2
DW, 16, signed operand width
AW, 40, signed accumulator width, AW >= 2*DW
KW, 8, width of k_len
CW, 16, width of the busy-cycle counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin job; sampled in IDLE only
k_len  in  KW  number of operand beats K, latched on start
busy  out  1  high in any state other than IDLE
in_valid  in  1  operand beat valid
in_ready  out  1  engine accepts beat
a_col  in  N*DW  column k of A; lane i = A[i][k]
b_row  in  N*DW  row k of B; lane j = B[k][j]
out_valid  out  1  result row valid
out_ready  in  1  downstream accepts row
out_row  out  N*AW  row out_idx of C; lane j = C[out_idx][j]
out_idx  out  $clog2(N)  row index being presented
done  out  1  one-cycle pulse after the last row handshake
count  out  CW  busy-cycle counter

Behaviour:
- Reset (rst = 0, asynchronous): FSM = IDLE; all accumulators, skew registers and PE pipes = 0; in_ready, out_valid, done, busy = 0; out_idx = 0; count = 0. Assertion mid-job aborts the job immediately, with no done pulse.
- FSM states: IDLE, LOAD, FLUSH, OUT.
- IDLE:
  - start = 1 clears all accumulators, clears count and latches k_len.
  - Next state is LOAD if k_len != 0; otherwise OUT, which presents all-zero C.
  - start in any other state is ignored.
- LOAD:
  - in_ready = 1.
  - A beat is accepted on in_valid & in_ready.
  - Lane i of a_col enters row i after an i-cycle skew. Lane j of b_row enters column j after a j-cycle skew.
  - a values move one PE right per cycle; b values move one PE down per cycle.
  - Each PE(i,j) performs acc += a*b every cycle. The product is signed DW x DW, sign-extended to AW, and wraps modulo 2^AW.
  - A cycle with in_valid = 0 injects zeros into both a and b. Skew alignment is preserved and the result is unaffected.
  - When the accepted-beat count equals the latched K, the FSM goes to FLUSH. in_ready drops in the cycle after the last accept.
- FLUSH:
  - Lasts exactly 2N-1 cycles so the last beat reaches PE(N-1,N-1). Zeros are injected throughout.
  - Next state is OUT.
- OUT:
  - out_valid = 1; out_row holds the accumulators of row out_idx, stable while out_ready = 0.
  - On out_valid & out_ready, out_idx increments.
  - On the handshake with out_idx = N-1: done = 1 for the next cycle, out_idx returns to 0, and the FSM goes to IDLE.
  - Accumulators keep C until the next start.
- count: increments on every cycle with busy = 1 and saturates at 2^CW-1. It holds its value in IDLE, so it stays readable after done.
- Latency: with no bubbles and out_ready = 1, the first out_valid occurs K + 2N - 1 cycles after the first beat accept. The job ends N cycles later.

Optional Feature:
- Macro: SYSARR_SAT_EN.
- Defined: each accumulator update saturates to [-2^(AW-1), 2^(AW-1)-1]. A sticky per-job flag is exposed as an extra output port, sat_flag (1 bit). sat_flag is cleared on start and set if any PE clamps.
- Undefined: updates wrap modulo 2^AW, and the sat_flag port is absent.

Test Plan:
- Identity: N=4, K=4, beat k drives a_col lane k = 1 and b_row lane k = 1 (all other lanes 0) -> C = I (diagonal 1, off-diagonal 0), done after 4 rows, count = 4+7+4.
- All-ones: K=4, every lane = 1 -> every C entry = 4. Repeat with in_valid low on alternate cycles -> identical C, larger count.
- Outer product: K=1, a_col = {1,2,3,4}, b_row = {5,6,7,8} -> C[i][j] = a_i*b_j, e.g. C[3][3] = 32.
- Signed and backpressure: a = -3, b = 7 in all lanes, K=2, out_ready toggling 1-0-1 -> all entries -42; out_row stable while stalled; out_idx goes 0..3 with no skipped rows.
- Edge cases: k_len = 0 -> OUT immediately with all-zero rows. rst low during LOAD -> busy = 0, out_valid = 0, no done pulse. A following job with K=1, a=b=2 -> all entries 4.
- With SYSARR_SAT_EN, DW=16, AW=32: K=3, a = b = -32768 (products 2^30, exact sum 3*2^30 = 0xC0000000) -> entries 0x7FFFFFFF, sat_flag = 1. Without the macro -> entries 0xC0000000.
